// File: rtl/mtl_sopc_sysid_checker.sv
// Avalon-MM read sequencer for the sysid slave. It reads the ID and timestamp words and
// compares them against expected values, with a per-read stall timeout and bounded retry.
module mtl_sopc_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1386398321,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          MAX_RETRIES        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic        timeout,
   output logic [3:0]  retry_count,
   output logic [31:0] read_id,
   output logic [31:0] read_ts
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ID   = 3'd1,
      RD_TS   = 3'd2,
      BACKOFF = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int              SW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0]   STALL_LAST  = SW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0]   STALL_MAX   = {SW{1'b1}};
   localparam logic [3:0]      RETRY_LIMIT = 4'(MAX_RETRIES);

   state_t        state_r, state_s;
   logic          boot_pending_r, boot_pending_s;
   logic          resume_ts_r, resume_ts_s;
   logic [SW-1:0] stall_cnt_r, stall_cnt_s;
   logic [3:0]    retry_r, retry_s;
   logic          id_ok_r, id_ok_s;
   logic          ts_ok_r, ts_ok_s;
   logic          timeout_r, timeout_s;
   logic [31:0]   read_id_r, read_id_s;
   logic [31:0]   read_ts_r, read_ts_s;
   logic          busy_r, done_r, pass_r;
   logic          busy_s, done_s, pass_s;

   // Next-state and next-value logic for the check sequencer.
   always_comb begin
      state_s        = state_r;
      boot_pending_s = boot_pending_r;
      resume_ts_s    = resume_ts_r;
      stall_cnt_s    = stall_cnt_r;
      retry_s        = retry_r;
      id_ok_s        = id_ok_r;
      ts_ok_s        = ts_ok_r;
      timeout_s      = timeout_r;
      read_id_s      = read_id_r;
      read_ts_s      = read_ts_r;
      case (state_r)
         IDLE, DONE: begin
            if (((state_r == IDLE) && boot_pending_r) || start) begin
               state_s        = RD_ID;
               boot_pending_s = 1'b0;
               resume_ts_s    = 1'b0;
               stall_cnt_s    = {SW{1'b0}};
               retry_s        = 4'd0;
               id_ok_s        = 1'b0;
               ts_ok_s        = 1'b0;
               timeout_s      = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         RD_ID, RD_TS: begin
            if (!m_waitrequest) begin
               stall_cnt_s = {SW{1'b0}};
               if (state_r == RD_ID) begin
                  read_id_s = m_readdata;
                  state_s   = RD_TS;
               end else begin
                  read_ts_s = m_readdata;
                  state_s   = CHECK;
               end
            end else if (stall_cnt_r == STALL_LAST) begin
               // Abandon this read; BACKOFF decides between retry and giving up.
               state_s     = BACKOFF;
               retry_s     = retry_r + 4'd1;
               stall_cnt_s = {SW{1'b0}};
               resume_ts_s = (state_r == RD_TS);
            end else if (stall_cnt_r != STALL_MAX) begin
               stall_cnt_s = stall_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
               stall_cnt_s = stall_cnt_r;
            end
         end
         BACKOFF: begin
            if (retry_r == RETRY_LIMIT) begin
               state_s   = DONE;
               timeout_s = 1'b1;
               id_ok_s   = 1'b0;
               ts_ok_s   = 1'b0;
            end else begin
               state_s = resume_ts_r ? RD_TS : RD_ID;
            end
         end
         CHECK: begin
            id_ok_s = (read_id_r == EXPECTED_ID);
            ts_ok_s = (read_ts_r == EXPECTED_TIMESTAMP);
            state_s = DONE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s == RD_ID) || (state_s == RD_TS) || (state_s == BACKOFF) || (state_s == CHECK);
      done_s = (state_s == DONE);
      pass_s = done_s && id_ok_s && ts_ok_s;
   end

   // State and status registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= IDLE;
         boot_pending_r <= 1'b1;
         resume_ts_r    <= 1'b0;
         stall_cnt_r    <= {SW{1'b0}};
         retry_r        <= 4'd0;
         id_ok_r        <= 1'b0;
         ts_ok_r        <= 1'b0;
         timeout_r      <= 1'b0;
         read_id_r      <= 32'd0;
         read_ts_r      <= 32'd0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         boot_pending_r <= boot_pending_s;
         resume_ts_r    <= resume_ts_s;
         stall_cnt_r    <= stall_cnt_s;
         retry_r        <= retry_s;
         id_ok_r        <= id_ok_s;
         ts_ok_r        <= ts_ok_s;
         timeout_r      <= timeout_s;
         read_id_r      <= read_id_s;
         read_ts_r      <= read_ts_s;
         busy_r         <= busy_s;
         done_r         <= done_s;
         pass_r         <= pass_s;
      end
   end

   // Bus strobes are decoded straight from the state register so they hold during stalls.
   always_comb begin
      m_read    = (state_r == RD_ID) || (state_r == RD_TS);
      m_address = (state_r == RD_TS);
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign id_ok       = id_ok_r;
   assign ts_ok       = ts_ok_r;
   assign pass        = pass_r;
   assign timeout     = timeout_r;
   assign retry_count = retry_r;
   assign read_id     = read_id_r;
   assign read_ts     = read_ts_r;

endmodule

// File: tb/tb_mtl_sopc_sysid_checker.sv
// Directed bench for mtl_sopc_sysid_checker: a default instance with a programmable wait-state
// slave, plus a short-timeout instance whose slave never completes.
module tb_mtl_sopc_sysid_checker;

   localparam logic [31:0] TS_GOOD = 32'd1386398321;

   logic        clk = 1'b0;
   logic        reset, start, start_b;
   logic [31:0] id_val, ts_val;
   int          wait_n, wait_cnt;
   int          checks = 0;
   int          failures = 0;

   logic        a_m_address, a_m_read, a_m_waitrequest;
   logic [31:0] a_m_readdata, a_read_id, a_read_ts;
   logic        a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout;
   logic [3:0]  a_retry_count;

   logic        b_m_address, b_m_read;
   logic [31:0] b_read_id, b_read_ts;
   logic        b_busy, b_done, b_id_ok, b_ts_ok, b_pass, b_timeout;
   logic [3:0]  b_retry_count;

   always #5 clk = ~clk;

   assign a_m_readdata    = a_m_address ? ts_val : id_val;
   assign a_m_waitrequest = a_m_read && (wait_cnt < wait_n);

   always @(posedge clk) begin
      if (!a_m_read) wait_cnt <= 0;
      else if (a_m_waitrequest) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   mtl_sopc_sysid_checker dut_a (
      .clock(clk), .reset(reset), .start(start),
      .m_address(a_m_address), .m_read(a_m_read), .m_waitrequest(a_m_waitrequest),
      .m_readdata(a_m_readdata), .busy(a_busy), .done(a_done), .id_ok(a_id_ok),
      .ts_ok(a_ts_ok), .pass(a_pass), .timeout(a_timeout), .retry_count(a_retry_count),
      .read_id(a_read_id), .read_ts(a_read_ts)
   );

   mtl_sopc_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) dut_b (
      .clock(clk), .reset(reset), .start(start_b),
      .m_address(b_m_address), .m_read(b_m_read), .m_waitrequest(1'b1),
      .m_readdata(32'd0), .busy(b_busy), .done(b_done), .id_ok(b_id_ok),
      .ts_ok(b_ts_ok), .pass(b_pass), .timeout(b_timeout), .retry_count(b_retry_count),
      .read_id(b_read_id), .read_ts(b_read_ts)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_b = 1'b0;
      id_val = 32'd0; ts_val = TS_GOOD; wait_n = 0;
      step(2);
      chk("rst_m_read", a_m_read, 1'b0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_retry", a_retry_count, 4'd0);
      chk("rst_read_id", a_read_id, 32'd0);
      chk("rst_pass", a_pass, 1'b0);

      // Boot check, zero-wait slave (cycle R)
      reset = 1'b0;
      step(1);
      chk("boot_r1_m_read", a_m_read, 1'b1);
      chk("boot_r1_m_address", a_m_address, 1'b0);
      chk("boot_r1_busy", a_busy, 1'b1);
      step(2);
      chk("boot_r3_done", a_done, 1'b0);
      chk("tmo_r3_m_read", b_m_read, 1'b1);
      step(1);
      chk("boot_r4_done", a_done, 1'b1);
      chk("boot_r4_pass", a_pass, 1'b1);
      chk("boot_r4_retry", a_retry_count, 4'd0);
      chk("boot_r4_read_ts", a_read_ts, TS_GOOD);
      chk("boot_r4_busy", a_busy, 1'b0);

      // Stuck slave on short-timeout instance
      step(1);
      chk("tmo_r5_m_read", b_m_read, 1'b0);
      chk("tmo_r5_busy", b_busy, 1'b1);
      chk("tmo_r5_retry", b_retry_count, 4'd1);
      step(1);
      chk("tmo_r6_m_read", b_m_read, 1'b1);
      step(4);
      chk("tmo_r10_m_read", b_m_read, 1'b0);
      chk("tmo_r10_retry", b_retry_count, 4'd2);
      chk("tmo_r10_done", b_done, 1'b0);
      step(1);
      chk("tmo_r11_done", b_done, 1'b1);
      chk("tmo_r11_timeout", b_timeout, 1'b1);
      chk("tmo_r11_retry", b_retry_count, 4'd2);
      chk("tmo_r11_pass", b_pass, 1'b0);
      chk("tmo_r11_m_address", b_m_address, 1'b0);

      // ID mismatch via start
      id_val = 32'h0000_0005;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("idm_s1_done", a_done, 1'b0);
      chk("idm_s1_busy", a_busy, 1'b1);
      step(3);
      chk("idm_s4_done", a_done, 1'b1);
      chk("idm_s4_id_ok", a_id_ok, 1'b0);
      chk("idm_s4_ts_ok", a_ts_ok, 1'b1);
      chk("idm_s4_pass", a_pass, 1'b0);
      chk("idm_s4_read_id", a_read_id, 32'd5);
      chk("idm_s4_retry", a_retry_count, 4'd0);
      step(2);
      chk("idm_final_done", a_done, 1'b1);
      chk("idm_final_m_read", a_m_read, 1'b0);

      // Timestamp mismatch; starts while busy are ignored
      id_val = 32'd0; ts_val = 32'd0;
      start = 1'b1;
      step(1);
      chk("tsm_s1_done", a_done, 1'b0);
      step(1);
      start = 1'b0;
      step(1);
      chk("tsm_s3_done", a_done, 1'b0);
      step(1);
      chk("tsm_s4_done", a_done, 1'b1);
      chk("tsm_s4_ts_ok", a_ts_ok, 1'b0);
      chk("tsm_s4_id_ok", a_id_ok, 1'b1);
      chk("tsm_s4_pass", a_pass, 1'b0);
      chk("tsm_s4_read_ts", a_read_ts, 32'd0);
      step(2);
      chk("tsm_s6_done", a_done, 1'b1);
      chk("tsm_s6_busy", a_busy, 1'b0);

      // Three wait states per word after reset
      ts_val = TS_GOOD; wait_n = 3;
      reset = 1'b1;
      step(1);
      chk("ws_rst_m_read", a_m_read, 1'b0);
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step(1);
         chk("ws_m_read", a_m_read, 1'b1);
         chk("ws_m_address", a_m_address, (c > 4) ? 32'd1 : 32'd0);
      end
      step(1);
      chk("ws_r9_m_read", a_m_read, 1'b0);
      chk("ws_r9_done", a_done, 1'b0);
      step(1);
      chk("ws_r10_done", a_done, 1'b1);
      chk("ws_r10_pass", a_pass, 1'b1);

      // Reset during an RD_TS stall, coincident with start
      wait_n = 5;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(8);
      chk("mid_s9_m_address", a_m_address, 1'b1);
      chk("mid_s9_m_read", a_m_read, 1'b1);
      reset = 1'b1; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("mid_rst_m_read", a_m_read, 1'b0);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_read_id", a_read_id, 32'd0);
      chk("mid_rst_read_ts", a_read_ts, 32'd0);
      chk("mid_rst_done", a_done, 1'b0);
      wait_n = 0; reset = 1'b0;
      step(1);
      chk("mid_r1_m_read", a_m_read, 1'b1);
      step(3);
      chk("mid_r4_done", a_done, 1'b1);
      chk("mid_r4_pass", a_pass, 1'b1);
      chk("mid_r4_read_ts", a_read_ts, TS_GOOD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
